// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared seven-segment constants used by both the BCD-to-segment driver and
// the receive-side frame capture. Patterns are {a,b,c,d,e,f,g}, active-high,
// with seg[6]=a ... seg[0]=g.
// Ports: none (package).
// ----------------------------------------------------------------------------
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Value reported for any pattern that is not a legal 0-9 digit.
   localparam logic [3:0] NIBBLE_INVALID = 4'hF;

endpackage

// File: rtl/seg_pattern_decode.sv
// ----------------------------------------------------------------------------
// seg_pattern_decode
// Combinational inverse of the seven-segment driver table: maps a segment
// pattern back to its BCD value.
// Ports:
//   seg   in  [6:0]  segment lines, seg[6]=a ... seg[0]=g
//   value out [3:0]  decoded digit 0-9, NIBBLE_INVALID when not legal
//   err   out        1 when the pattern is not one of the ten digit codes
// ----------------------------------------------------------------------------
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] value,
   output logic       err
);

   always_comb begin
      value = NIBBLE_INVALID;
      err   = 1'b0;
      case (seg)
         SEG_0:   value = 4'd0;
         SEG_1:   value = 4'd1;
         SEG_2:   value = 4'd2;
         SEG_3:   value = 4'd3;
         SEG_4:   value = 4'd4;
         SEG_5:   value = 4'd5;
         SEG_6:   value = 4'd6;
         SEG_7:   value = 4'd7;
         SEG_8:   value = 4'd8;
         SEG_9:   value = 4'd9;
         default: begin
            value = NIBBLE_INVALID;
            err   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seg_frame_capture.sv
// ----------------------------------------------------------------------------
// seg_frame_capture
// Samples a multiplexed seven-segment bus, debounces each digit dwell,
// decodes the pattern back to BCD and assembles a NUM_DIGITS frame that is
// handed out over a valid/ready handshake.
// Ports:
//   clk          in                 system clock, rising edge
//   rst_n        in                 synchronous active-low reset
//   seg          in  [6:0]          segment lines, seg[6]=a ... seg[0]=g
//   dig_sel      in  [NUM_DIGITS]   one-hot digit strobes
//   frame_data   out [4*NUM_DIGITS] captured BCD, digit i at [4i+3:4i]
//   frame_err    out [NUM_DIGITS]   digit i pattern was not a legal 0-9 code
//   frame_valid  out                frame_data/frame_err hold a frame
//   frame_ready  in                 consumer accepts on valid && ready
//   overrun      out                sticky: a completed frame was dropped
// ----------------------------------------------------------------------------
module seg_frame_capture
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   output logic [4*NUM_DIGITS-1:0] frame_data,
   output logic [NUM_DIGITS-1:0]   frame_err,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic                    overrun
);

   localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

   logic [3:0] dec_value;
   logic       dec_err;

   seg_pattern_decode u_decode (
      .seg   (seg),
      .value (dec_value),
      .err   (dec_err)
   );

   logic [NUM_DIGITS-1:0]   prev_sel_q,    prev_sel_d;
   logic [6:0]              prev_seg_q,    prev_seg_d;
   logic [7:0]              cnt_q,         cnt_d;
   logic [NUM_DIGITS-1:0]   captured_q,    captured_d;
   logic [4*NUM_DIGITS-1:0] stage_data_q,  stage_data_d;
   logic [NUM_DIGITS-1:0]   stage_err_q,   stage_err_d;
   logic [4*NUM_DIGITS-1:0] frame_data_q,  frame_data_d;
   logic [NUM_DIGITS-1:0]   frame_err_q,   frame_err_d;
   logic                    frame_valid_q, frame_valid_d;
   logic                    overrun_q,     overrun_d;

   logic sel_onehot;
   logic same_sample;
   logic capture;
   logic frame_full;
   logic frame_load;

   always_comb begin
      sel_onehot  = $onehot(dig_sel);
      same_sample = (dig_sel == prev_sel_q) && (seg == prev_seg_q);
      prev_sel_d  = dig_sel;
      prev_seg_d  = seg;

      // Dwell counter: saturating run length of identical one-hot samples.
      cnt_d = cnt_q;
      if (sel_onehot && same_sample) begin
         if (cnt_q < STABLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
         end
      end else if (sel_onehot) begin
         cnt_d = 8'd1;
      end else begin
         cnt_d = '0;
      end

      // Fire once per dwell, on the sample where the run length reaches the
      // threshold; a dwell already held at saturation must not refire. The
      // load path covers STABLE_CYCLES=1 between back-to-back dwells.
      capture = sel_onehot && (cnt_d == STABLE_MAX) &&
                !(same_sample && (cnt_q == STABLE_MAX));

      // A full mask from the previous cycle hands the staged frame out (or
      // drops it) this cycle; a capture in the same cycle starts the next frame.
      frame_full = &captured_q;
      frame_load = frame_full && (!frame_valid_q || frame_ready);

      captured_d   = frame_full ? '0 : captured_q;
      stage_data_d = stage_data_q;
      stage_err_d  = stage_err_q;
      if (capture) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (dig_sel[i]) begin
               captured_d[i]            = 1'b1;
               stage_data_d[4*i +: 4]   = dec_value;
               stage_err_d[i]           = dec_err;
            end
         end
      end

      frame_data_d  = frame_data_q;
      frame_err_d   = frame_err_q;
      frame_valid_d = frame_valid_q;
      if (frame_load) begin
         frame_data_d  = stage_data_q;
         frame_err_d   = stage_err_q;
         frame_valid_d = 1'b1;
      end else if (frame_valid_q && frame_ready) begin
         frame_valid_d = 1'b0;
      end

      overrun_d = overrun_q | (frame_full && !frame_load);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_sel_q    <= '0;
         prev_seg_q    <= '0;
         cnt_q         <= '0;
         captured_q    <= '0;
         stage_data_q  <= '0;
         stage_err_q   <= '0;
         frame_data_q  <= '0;
         frame_err_q   <= '0;
         frame_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         prev_sel_q    <= prev_sel_d;
         prev_seg_q    <= prev_seg_d;
         cnt_q         <= cnt_d;
         captured_q    <= captured_d;
         stage_data_q  <= stage_data_d;
         stage_err_q   <= stage_err_d;
         frame_data_q  <= frame_data_d;
         frame_err_q   <= frame_err_d;
         frame_valid_q <= frame_valid_d;
         overrun_q     <= overrun_d;
      end
   end

   assign frame_data  = frame_data_q;
   assign frame_err   = frame_err_q;
   assign frame_valid = frame_valid_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg_frame_capture.sv
// ----------------------------------------------------------------------------
// tb_seg_frame_capture
// Bench for seg_frame_capture (NUM_DIGITS=4, STABLE_CYCLES=3). A run-length
// reference model tracks every cycle; directed sequences and a decode table
// add constant expectations.
// ----------------------------------------------------------------------------
module tb_seg_frame_capture;

   localparam int unsigned ND = 4;
   localparam int          SC = 3;

   logic        clk;
   logic        rst_n;
   logic [6:0]  seg;
   logic [3:0]  dig_sel;
   logic [15:0] frame_data;
   logic [3:0]  frame_err;
   logic        frame_valid;
   logic        frame_ready;
   logic        overrun;

   seg_frame_capture #(
      .NUM_DIGITS    (ND),
      .STABLE_CYCLES (SC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg         (seg),
      .dig_sel     (dig_sel),
      .frame_data  (frame_data),
      .frame_err   (frame_err),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Digit patterns {a..g}, written out independently of the design package.
   function automatic logic [6:0] ref_pat(input int k);
      case (k)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         default: return 7'b1111011;
      endcase
   endfunction

   // Returns {err, value}.
   function automatic logic [4:0] ref_decode(input logic [6:0] s);
      for (int k = 0; k < 10; k++) begin
         if (s == ref_pat(k)) return {1'b0, 4'(k)};
      end
      return 5'h1F;
   endfunction

   // Reference model state: unbounded run length, per-digit staging, outputs.
   int          run_len;
   logic [3:0]  last_sel;
   logic [6:0]  last_seg;
   logic        cap    [ND];
   logic [3:0]  st_val [ND];
   logic        st_err [ND];
   logic [15:0] m_data;
   logic [3:0]  m_err;
   logic        m_valid;
   logic        m_ovr;

   task automatic model_edge(input logic r, input logic [6:0] s,
                             input logic [3:0] d, input logic rd);
      bit         full;
      bit         oh;
      int         idx;
      logic [4:0] dv;
      if (!r) begin
         run_len  = 0;
         last_sel = '0;
         last_seg = '0;
         for (int i = 0; i < ND; i++) begin
            cap[i] = 1'b0; st_val[i] = '0; st_err[i] = 1'b0;
         end
         m_data = '0; m_err = '0; m_valid = 1'b0; m_ovr = 1'b0;
         return;
      end
      full = 1'b1;
      for (int i = 0; i < ND; i++) if (cap[i] !== 1'b1) full = 1'b0;
      if (full) begin
         if (!m_valid || rd) begin
            for (int i = 0; i < ND; i++) begin
               m_data[4*i +: 4] = st_val[i];
               m_err[i]         = st_err[i];
            end
            m_valid = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
         for (int i = 0; i < ND; i++) cap[i] = 1'b0;
      end else if (m_valid && rd) begin
         m_valid = 1'b0;
      end
      oh = ($countones(d) == 1);
      if (oh && d == last_sel && s == last_seg) run_len++;
      else run_len = oh ? 1 : 0;
      if (oh && run_len == SC) begin
         idx = 0;
         for (int i = 0; i < ND; i++) if (d[i]) idx = i;
         dv = ref_decode(s);
         st_val[idx] = dv[3:0];
         st_err[idx] = dv[4];
         cap[idx]    = 1'b1;
      end
      last_sel = d;
      last_seg = s;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model on the edge, compare after it.
   task automatic step(input logic r, input logic [6:0] s, input logic [3:0] d, input logic rd);
      rst_n = r; seg = s; dig_sel = d; frame_ready = rd;
      @(posedge clk);
      model_edge(r, s, d, rd);
      #1;
      chk("model {valid,ovr,err,data}", 32'({frame_valid, overrun, frame_err, frame_data}),
          32'({m_valid, m_ovr, m_err, m_data}));
   endtask

   task automatic digit(input int d, input logic [6:0] p, input int n, input logic rd);
      for (int k = 0; k < n; k++) step(1'b1, p, 4'(1 << d), rd);
   endtask

   task automatic gap(input logic rd);
      step(1'b1, 7'b0000000, 4'b0000, rd);
   endtask

   task automatic expect_out(input string name, input logic v, input logic [15:0] dat,
                             input logic [3:0] e, input logic o);
      chk(name, 32'({frame_valid, overrun, frame_err, frame_data}), 32'({v, o, e, dat}));
   endtask

   typedef struct {
      logic [6:0] pat;
      logic [3:0] nib;
      logic       err;
   } dec_vec_t;

   dec_vec_t    tbl [14];
   int          slot;
   logic [6:0]  p;
   logic [3:0]  sel;
   logic [15:0] exp_data;
   logic [3:0]  exp_err;
   int          r;
   int          len;
   logic        rs;
   logic        rd;

   initial begin
      tbl[0]  = '{pat: 7'b1111110, nib: 4'h0, err: 1'b0};
      tbl[1]  = '{pat: 7'b0110000, nib: 4'h1, err: 1'b0};
      tbl[2]  = '{pat: 7'b1101101, nib: 4'h2, err: 1'b0};
      tbl[3]  = '{pat: 7'b1111001, nib: 4'h3, err: 1'b0};
      tbl[4]  = '{pat: 7'b0110011, nib: 4'h4, err: 1'b0};
      tbl[5]  = '{pat: 7'b1011011, nib: 4'h5, err: 1'b0};
      tbl[6]  = '{pat: 7'b1011111, nib: 4'h6, err: 1'b0};
      tbl[7]  = '{pat: 7'b1110000, nib: 4'h7, err: 1'b0};
      tbl[8]  = '{pat: 7'b1111111, nib: 4'h8, err: 1'b0};
      tbl[9]  = '{pat: 7'b1111011, nib: 4'h9, err: 1'b0};
      tbl[10] = '{pat: 7'b0000000, nib: 4'hF, err: 1'b1};
      tbl[11] = '{pat: 7'b0000001, nib: 4'hF, err: 1'b1};
      tbl[12] = '{pat: 7'b1111101, nib: 4'hF, err: 1'b1};
      tbl[13] = '{pat: 7'b0111111, nib: 4'hF, err: 1'b1};

      // Reset with arbitrary inputs.
      step(1'b0, 7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)), 1'b1);
      step(1'b0, 7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)), 1'b0);
      expect_out("reset", 1'b0, 16'h0000, 4'h0, 1'b0);

      // Clean frame 1,2,9,0 with latency check on digit 3.
      digit(0, ref_pat(1), 4, 1'b1); gap(1'b1);
      digit(1, ref_pat(2), 4, 1'b1); gap(1'b1);
      digit(2, ref_pat(9), 4, 1'b1); gap(1'b1);
      digit(3, ref_pat(0), 3, 1'b1);
      expect_out("clean_before_latency", 1'b0, 16'h0000, 4'h0, 1'b0);
      digit(3, ref_pat(0), 1, 1'b1);
      expect_out("clean_frame", 1'b1, 16'h0921, 4'h0, 1'b0);
      gap(1'b1);
      chk("clean_valid_drop", 32'(frame_valid), 32'(0));

      // Glitch rejection: 8 shown too briefly, 3 captured.
      digit(0, ref_pat(8), 2, 1'b1);
      digit(0, ref_pat(3), 3, 1'b1); gap(1'b1);
      digit(1, ref_pat(4), 4, 1'b1); gap(1'b1);
      digit(2, ref_pat(5), 4, 1'b1); gap(1'b1);
      digit(3, ref_pat(6), 4, 1'b1);
      expect_out("glitch_frame", 1'b1, 16'h6543, 4'h0, 1'b0);
      gap(1'b1);

      // Invalid pattern on digit 2.
      digit(0, ref_pat(1), 4, 1'b1); gap(1'b1);
      digit(1, ref_pat(2), 4, 1'b1); gap(1'b1);
      digit(2, 7'b0000001, 3, 1'b1); gap(1'b1);
      digit(3, ref_pat(4), 4, 1'b1);
      expect_out("invalid_frame", 1'b1, 16'h4F21, 4'b0100, 1'b0);
      gap(1'b1);

      // Decode table: each entry placed in a rotating slot, other digits 0.
      for (int k = 0; k < 14; k++) begin
         slot = k % 4;
         for (int d = 0; d < 4; d++) begin
            p = (d == slot) ? tbl[k].pat : ref_pat(0);
            digit(d, p, 4, 1'b1);
            if (d < 3) gap(1'b1);
         end
         exp_data = 16'(tbl[k].nib) << (4 * slot);
         exp_err  = 4'(tbl[k].err) << slot;
         expect_out("decode_tbl", 1'b1, exp_data, exp_err, 1'b0);
         gap(1'b1);
      end

      // Backpressure: first frame held, second frame dropped.
      digit(0, ref_pat(7), 4, 1'b0); gap(1'b0);
      digit(1, ref_pat(8), 4, 1'b0); gap(1'b0);
      digit(2, ref_pat(9), 4, 1'b0); gap(1'b0);
      digit(3, ref_pat(0), 4, 1'b0);
      expect_out("bp_first", 1'b1, 16'h0987, 4'h0, 1'b0);
      gap(1'b0);
      digit(0, ref_pat(1), 4, 1'b0); gap(1'b0);
      digit(1, ref_pat(2), 4, 1'b0); gap(1'b0);
      digit(2, ref_pat(3), 4, 1'b0); gap(1'b0);
      digit(3, ref_pat(4), 4, 1'b0);
      expect_out("bp_overrun", 1'b1, 16'h0987, 4'h0, 1'b1);
      gap(1'b1);
      expect_out("bp_accept", 1'b0, 16'h0987, 4'h0, 1'b1);
      gap(1'b0);

      // Multi-hot strobes must not capture digit 0 or 1.
      step(1'b1, ref_pat(5), 4'b0011, 1'b1);
      for (int k = 0; k < 4; k++) step(1'b1, ref_pat(5), 4'b0011, 1'b1);
      gap(1'b1);
      digit(1, ref_pat(6), 4, 1'b1); gap(1'b1);
      digit(2, ref_pat(7), 4, 1'b1); gap(1'b1);
      digit(3, ref_pat(8), 4, 1'b1); gap(1'b1);
      chk("multihot_no_frame", 32'(frame_valid), 32'(0));
      digit(0, ref_pat(9), 4, 1'b1);
      expect_out("multihot_frame", 1'b1, 16'h8769, 4'h0, 1'b1);
      gap(1'b1);

      // Reset mid-frame discards digits 0 and 1.
      digit(0, ref_pat(3), 4, 1'b1); gap(1'b1);
      digit(1, ref_pat(3), 4, 1'b1);
      step(1'b0, ref_pat(3), 4'b0010, 1'b1);
      expect_out("midreset", 1'b0, 16'h0000, 4'h0, 1'b0);
      digit(2, ref_pat(6), 4, 1'b1); gap(1'b1);
      digit(3, ref_pat(8), 4, 1'b1); gap(1'b1);
      chk("midreset_partial", 32'(frame_valid), 32'(0));
      digit(0, ref_pat(2), 4, 1'b1); gap(1'b1);
      digit(1, ref_pat(4), 4, 1'b1);
      expect_out("midreset_frame", 1'b1, 16'h8642, 4'h0, 1'b0);
      gap(1'b1);

      // Randomised dwells, strobes, readiness and occasional reset.
      for (int it = 0; it < 600; it++) begin
         r = $urandom_range(0, 9);
         if (r < 7)      sel = 4'(1 << $urandom_range(0, 3));
         else if (r < 8) sel = 4'b0000;
         else            sel = 4'($urandom_range(0, 15));
         r = $urandom_range(0, 9);
         p = (r < 8) ? ref_pat($urandom_range(0, 9)) : 7'($urandom_range(0, 127));
         len = $urandom_range(1, 5);
         rd = 1'b1;
         for (int c = 0; c < len; c++) begin
            rs = ($urandom_range(0, 299) != 0);
            rd = ($urandom_range(0, 2) != 0);
            step(rs, p, sel, rd);
         end
         if ($urandom_range(0, 1) == 1) gap(rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
